// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: datapath width, FSM
// state encoding and the data-burst counter helper.
package mem_arbiter_pkg;

  localparam int DP_WIDTH = 31;
  localparam int DCOUNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_DBUSY = 2'b01,
    ARB_IBUSY = 2'b10,
    ARB_DONE  = 2'b11
  } arb_state_e;

  function automatic logic [DCOUNT_W-1:0] sat_inc(input logic [DCOUNT_W-1:0] value,
                                                  input logic [DCOUNT_W-1:0] limit);
    return (value >= limit) ? limit : value + 4'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and memory command bus of the arbiter.
// The slave modport is the arbiter's view; master is the CPU/memory side.
interface mem_arbiter_if #(
  parameter int DP_WIDTH = mem_arbiter_pkg::DP_WIDTH
);
  import mem_arbiter_pkg::*;

  logic              IReq;
  logic [31:0]       IAddr;
  logic [DP_WIDTH:0] IData;
  logic              IReady;
  logic              IStall;

  logic              DRead;
  logic [3:0]        DWE;
  logic [31:0]       DAddr;
  logic [DP_WIDTH:0] DWData;
  logic [DP_WIDTH:0] DRData;
  logic              DReady;
  logic              DStall;

  logic [31:0]       MemAddr;
  logic [DP_WIDTH:0] MemWData;
  logic [3:0]        MemWE;
  logic              MemRE;
  logic              MemAck;
  logic [DP_WIDTH:0] MemRData;

  modport slave (
    input  IReq, IAddr, DRead, DWE, DAddr, DWData, MemAck, MemRData,
    output IData, IReady, IStall, DRData, DReady, DStall,
           MemAddr, MemWData, MemWE, MemRE
  );

  modport master (
    output IReq, IAddr, DRead, DWE, DAddr, DWData, MemAck, MemRData,
    input  IData, IReady, IStall, DRData, DReady, DStall,
           MemAddr, MemWData, MemWE, MemRE
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory between instruction fetch and data.
// Data has priority; a burst counter forces a fetch grant after MAX_DBURST data grants.
module mem_arbiter #(
  parameter int DP_WIDTH   = mem_arbiter_pkg::DP_WIDTH,
  parameter int MAX_DBURST = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  import mem_arbiter_pkg::*;

  localparam logic [DCOUNT_W-1:0] DBURST_LIM = DCOUNT_W'(MAX_DBURST);

  arb_state_e          state_q, state_d;
  logic [DCOUNT_W-1:0] dcount_q, dcount_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [DP_WIDTH:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic [DP_WIDTH:0]   idata_q, idata_d;
  logic [DP_WIDTH:0]   drdata_q, drdata_d;
  logic                iready_q, iready_d;
  logic                dready_q, dready_d;
  logic                ilive_q, ilive_d;
  logic                d_req;
  logic                starve;

  assign d_req  = bus.DRead | (bus.DWE != 4'b0000);
  assign starve = bus.IReq & (dcount_q == DBURST_LIM);

  always_comb begin
    state_d     = state_q;
    dcount_d    = dcount_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_re_d    = mem_re_q;
    idata_d     = idata_q;
    drdata_d    = drdata_q;
    iready_d    = 1'b0;
    dready_d    = 1'b0;
    ilive_d     = ilive_q;

    case (state_q)
      ARB_IDLE: begin
        if (d_req && !starve) begin
          state_d     = ARB_DBUSY;
          mem_addr_d  = bus.DAddr;
          mem_wdata_d = bus.DWData;
          mem_we_d    = bus.DWE;
          mem_re_d    = (bus.DWE == 4'b0000);
          dcount_d    = bus.IReq ? sat_inc(dcount_q, DBURST_LIM) : '0;
        end else if (bus.IReq) begin
          state_d     = ARB_IBUSY;
          mem_addr_d  = bus.IAddr;
          mem_wdata_d = '0;
          mem_we_d    = 4'b0000;
          mem_re_d    = 1'b1;
          dcount_d    = '0;
          ilive_d     = 1'b1;
        end else begin
          dcount_d    = '0;
        end
      end

      ARB_DBUSY: begin
        if (bus.MemAck) begin
          if (mem_re_q) begin
            drdata_d = bus.MemRData;
          end
          dready_d    = 1'b1;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_we_d    = 4'b0000;
          mem_re_d    = 1'b0;
          state_d     = ARB_DONE;
        end
      end

      ARB_IBUSY: begin
        // A fetch dropped at any point of the access is discarded on completion.
        ilive_d = ilive_q & bus.IReq;
        if (bus.MemAck) begin
          if (ilive_d) begin
            idata_d  = bus.MemRData;
            iready_d = 1'b1;
          end
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_we_d    = 4'b0000;
          mem_re_d    = 1'b0;
          state_d     = ARB_DONE;
        end
      end

      ARB_DONE: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      dcount_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 4'b0000;
      mem_re_q    <= 1'b0;
      idata_q     <= '0;
      drdata_q    <= '0;
      iready_q    <= 1'b0;
      dready_q    <= 1'b0;
      ilive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcount_q    <= dcount_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      idata_q     <= idata_d;
      drdata_q    <= drdata_d;
      iready_q    <= iready_d;
      dready_q    <= dready_d;
      ilive_q     <= ilive_d;
    end
  end

  assign bus.MemAddr  = mem_addr_q;
  assign bus.MemWData = mem_wdata_q;
  assign bus.MemWE    = mem_we_q;
  assign bus.MemRE    = mem_re_q;
  assign bus.IData    = idata_q;
  assign bus.DRData   = drdata_q;
  assign bus.IReady   = iready_q;
  assign bus.DReady   = dready_q;
  assign bus.IStall   = bus.IReq & ~iready_q;
  assign bus.DStall   = d_req & ~dready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a wait-state memory model plus per-port
// scoreboards of expected read data, checked on every ready pulse.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  int          compareCount = 0;
  int          failCount    = 0;
  int          waitStates   = 0;
  int          waitCnt      = 0;
  int          budget;
  logic [31:0] iQueue[$];
  logic [31:0] dQueue[$];
  logic [31:0] expIData;
  logic [31:0] expDRData;

  mem_arbiter_if bus();

  mem_arbiter #(
    .DP_WIDTH  (31),
    .MAX_DBURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr == 32'h0000_0040) return 32'h2402_0005;
    return {~addr[15:0], addr[15:0]} ^ 32'h0F0F_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dRead, input logic [3:0] dWe,
                               input logic [31:0] dAddr, input logic [31:0] dWData,
                               input int waits);
    bus.IReq   = iReq;
    bus.IAddr  = iAddr;
    bus.DRead  = dRead;
    bus.DWE    = dWe;
    bus.DAddr  = dAddr;
    bus.DWData = dWData;
    waitStates = waits;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
  endtask

  // Memory model: acks after waitStates idle cycles of an active command.
  always @(negedge clk) begin
    if (bus.MemRE || (bus.MemWE != 4'b0000)) begin
      if (waitCnt >= waitStates) begin
        bus.MemAck   = 1'b1;
        bus.MemRData = memWord(bus.MemAddr);
      end else begin
        bus.MemAck   = 1'b0;
        bus.MemRData = 32'hDEAD_BEEF;
        waitCnt++;
      end
    end else begin
      bus.MemAck   = 1'b0;
      bus.MemRData = 32'hDEAD_BEEF;
      waitCnt      = 0;
    end
  end

  always @(negedge clk) begin
    if (bus.IReady === 1'b1) begin
      if (iQueue.size() == 0) begin
        checkOutput("iReadyUnexpected", 32'(bus.IReady), 32'd0);
      end else begin
        expIData = iQueue.pop_front();
        checkOutput("iDataScoreboard", bus.IData, expIData);
      end
    end
    if (bus.DReady === 1'b1) begin
      if (dQueue.size() == 0) begin
        checkOutput("dReadyUnexpected", 32'(bus.DReady), 32'd0);
      end else begin
        expDRData = dQueue.pop_front();
        checkOutput("dRDataScoreboard", bus.DRData, expDRData);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b0;
    bus.MemAck   = 1'b0;
    bus.MemRData = 32'h0;
    expIData     = 32'h0;
    expDRData    = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 0);

    // Reset state
    nextCycle();
    midCycle();
    checkOutput("resetMemRE",   32'(bus.MemRE),   32'd0);
    checkOutput("resetMemWE",   32'(bus.MemWE),   32'd0);
    checkOutput("resetMemAddr", bus.MemAddr,      32'd0);
    checkOutput("resetIData",   bus.IData,        32'd0);
    checkOutput("resetDRData",  bus.DRData,       32'd0);
    checkOutput("resetReady",   32'({bus.IReady, bus.DReady}), 32'd0);
    checkOutput("resetState",   32'(dut.state_q), 32'(ARB_IDLE));
    checkOutput("resetDcount",  32'(dut.dcount_q), 32'd0);
    nextCycle();
    rst = 1'b1;

    // Single fetch, zero wait states
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0040, 1'b0, 4'b0000, 32'h0, 32'h0, 0);
    iQueue.push_back(32'h2402_0005);
    midCycle();
    checkOutput("fetchIStall",   32'(bus.IStall), 32'd1);
    checkOutput("fetchIdleNoRE", 32'(bus.MemRE),  32'd0);
    nextCycle();
    midCycle();
    checkOutput("fetchMemRE",   32'(bus.MemRE), 32'd1);
    checkOutput("fetchMemAddr", bus.MemAddr,    32'h0000_0040);
    checkOutput("fetchMemWE",   32'(bus.MemWE), 32'd0);
    nextCycle();
    midCycle();
    checkOutput("fetchIReady",    32'(bus.IReady), 32'd1);
    checkOutput("fetchIData",     bus.IData,       32'h2402_0005);
    checkOutput("fetchIStallOff", 32'(bus.IStall), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 0);
    midCycle();
    checkOutput("fetchReadyPulse", 32'(bus.IReady),  32'd0);
    checkOutput("fetchBackIdle",   32'(dut.state_q), 32'(ARB_IDLE));

    // Contention: data first, fetch granted from the IDLE cycle after DONE
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0080, 1'b1, 4'b0000, 32'h0000_0200, 32'h0, 0);
    dQueue.push_back(memWord(32'h0000_0200));
    iQueue.push_back(memWord(32'h0000_0080));
    nextCycle();
    midCycle();
    checkOutput("contDataAddr",  bus.MemAddr,      32'h0000_0200);
    checkOutput("contDataState", 32'(dut.state_q), 32'(ARB_DBUSY));
    checkOutput("contDcountInc", 32'(dut.dcount_q), 32'd1);
    nextCycle();
    midCycle();
    checkOutput("contDReady", 32'(bus.DReady), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0080, 1'b0, 4'b0000, 32'h0000_0200, 32'h0, 0);
    midCycle();
    checkOutput("contIdleGap", 32'(dut.state_q), 32'(ARB_IDLE));
    nextCycle();
    midCycle();
    checkOutput("contFetchAddr",  bus.MemAddr,      32'h0000_0080);
    checkOutput("contFetchState", 32'(dut.state_q), 32'(ARB_IBUSY));
    checkOutput("contDcountClr",  32'(dut.dcount_q), 32'd0);
    nextCycle();
    midCycle();
    checkOutput("contIReady", 32'(bus.IReady), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 0);

    // Byte write with two wait states
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 4'b0100, 32'h0000_0102, 32'hAAAA_AAAA, 2);
    dQueue.push_back(expDRData);
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      midCycle();
      checkOutput("writeMemWE",    32'(bus.MemWE),  32'b0100);
      checkOutput("writeMemRE",    32'(bus.MemRE),  32'd0);
      checkOutput("writeMemAddr",  bus.MemAddr,     32'h0000_0102);
      checkOutput("writeMemWData", bus.MemWData,    32'hAAAA_AAAA);
      checkOutput("writeDStall",   32'(bus.DStall), 32'd1);
    end
    nextCycle();
    midCycle();
    checkOutput("writeDReady",    32'(bus.DReady), 32'd1);
    checkOutput("writeDStallOff", 32'(bus.DStall), 32'd0);
    checkOutput("writeCmdClear",  32'(bus.MemWE),  32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 0);
    midCycle();
    checkOutput("writeReadyPulse", 32'(bus.DReady), 32'd0);

    // Starvation: four data grants, then the fetch
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0300, 1'b1, 4'b0000, 32'h0000_0400, 32'h0, 0);
    for (int k = 0; k < 4; k++) dQueue.push_back(memWord(32'h0000_0400));
    iQueue.push_back(memWord(32'h0000_0300));
    for (int g = 0; g < 5; g++) begin
      budget = 0;
      midCycle();
      while (!bus.MemRE && budget < 20) begin
        midCycle();
        budget++;
      end
      checkOutput("starveGrantSeen", 32'(bus.MemRE), 32'd1);
      checkOutput("starveGrantAddr", bus.MemAddr, (g < 4) ? 32'h0000_0400 : 32'h0000_0300);
      checkOutput("starveDcount", 32'(dut.dcount_q), 32'((g < 4) ? g + 1 : 0));
      budget = 0;
      midCycle();
      while (!(bus.IReady || bus.DReady) && budget < 20) begin
        midCycle();
        budget++;
      end
      checkOutput("starveReadySeen", 32'(bus.IReady | bus.DReady), 32'd1);
    end
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 0);

    // Fetch withdrawn during IBUSY
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0500, 1'b0, 4'b0000, 32'h0, 32'h0, 2);
    nextCycle();
    applyStimulus(1'b0, 32'h0000_0500, 1'b0, 4'b0000, 32'h0, 32'h0, 2);
    midCycle();
    checkOutput("withdrawState", 32'(dut.state_q), 32'(ARB_IBUSY));
    checkOutput("withdrawAddr",  bus.MemAddr,      32'h0000_0500);
    nextCycle();
    midCycle();
    nextCycle();
    midCycle();
    checkOutput("withdrawHoldRE", 32'(bus.MemRE), 32'd1);
    nextCycle();
    midCycle();
    checkOutput("withdrawDone",    32'(dut.state_q), 32'(ARB_DONE));
    checkOutput("withdrawNoReady", 32'(bus.IReady),  32'd0);
    checkOutput("withdrawIData",   bus.IData,        expIData);
    nextCycle();
    midCycle();
    checkOutput("withdrawIdle",      32'(dut.state_q), 32'(ARB_IDLE));
    checkOutput("withdrawIDataHeld", bus.IData,        expIData);

    // Asynchronous reset in the middle of a data write
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 4'b1111, 32'h0000_0600, 32'h1234_5678, 5);
    nextCycle();
    midCycle();
    checkOutput("rstMidWE",    32'(bus.MemWE),   32'b1111);
    checkOutput("rstMidState", 32'(dut.state_q), 32'(ARB_DBUSY));
    nextCycle();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rstAsyncWE",     32'(bus.MemWE),  32'd0);
    checkOutput("rstAsyncRE",     32'(bus.MemRE),  32'd0);
    checkOutput("rstAsyncDReady", 32'(bus.DReady), 32'd0);
    checkOutput("rstAsyncAddr",   bus.MemAddr,     32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 0);
    nextCycle();
    midCycle();
    nextCycle();
    rst = 1'b1;
    midCycle();
    checkOutput("rstReleaseState", 32'(dut.state_q), 32'(ARB_IDLE));
    checkOutput("rstClearsIData",  bus.IData,        32'd0);
    checkOutput("rstClearsDRData", bus.DRData,       32'd0);
    nextCycle();
    midCycle();
    checkOutput("rstNoDReady", 32'(bus.DReady), 32'd0);
    checkOutput("rstNoCmd",    32'(bus.MemWE),  32'd0);

    checkOutput("iQueueDrained", 32'(iQueue.size()), 32'd0);
    checkOutput("dQueueDrained", 32'(dQueue.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
